// File: rtl/mac_dot_sequencer.sv
// mac_dot_sequencer: turns a free-running 3-stage FP16 MAC into a dot-product engine
// (clear, feed one pair per cycle, drain pipeline, hold result behind valid/ready).
module mac_dot_sequencer #(
  parameter int LEN_W   = 8,
  parameter int MAC_LAT = 3
) (
  input  logic             clk,
  input  logic             Asynch_Reset_n,
  input  logic             start,
  input  logic [LEN_W-1:0] vec_len,
  input  logic             in_valid,
  input  logic [15:0]      in_a,
  input  logic [15:0]      in_b,
  output logic             in_ready,
  output logic [15:0]      mac_numA,
  output logic [15:0]      mac_numB,
  output logic             mac_rst,
  input  logic [15:0]      mac_acc,
  output logic             res_valid,
  output logic [15:0]      res_data,
  input  logic             res_ready,
  output logic             busy
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CLEAR = 3'd1;
  localparam logic [2:0] FEED  = 3'd2;
  localparam logic [2:0] DRAIN = 3'd3;
  localparam logic [2:0] HOLD  = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d, cnt_q, cnt_d;
  logic [15:0]      a_q, a_d, b_q, b_d, rd_q, rd_d;
  logic             mrst_q, mrst_d, rv_q, rv_d, hs;

  assign in_ready  = state_q == FEED;
  assign busy      = state_q != IDLE;
  assign mac_numA  = a_q;
  assign mac_numB  = b_q;
  assign mac_rst   = mrst_q;
  assign res_valid = rv_q;
  assign res_data  = rd_q;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    rv_d    = rv_q;
    rd_d    = rd_q;
    hs      = state_q == FEED && in_valid;
    a_d     = hs ? in_a : 16'h0000;
    b_d     = hs ? in_b : 16'h0000;
    mrst_d  = state_q == IDLE && start && vec_len != '0;
    case (state_q)
      IDLE: if (start) begin
        if (vec_len != '0) begin
          len_d   = vec_len;
          state_d = CLEAR;
        end else begin
          rd_d    = 16'h0000;
          rv_d    = 1'b1;
          state_d = HOLD;
        end
      end
      CLEAR: begin
        cnt_d   = '0;
        state_d = FEED;
      end
      FEED: if (hs) begin
        cnt_d = cnt_q + LEN_W'(1);
        if (cnt_q == len_q - LEN_W'(1)) begin
          cnt_d   = LEN_W'(MAC_LAT);
          state_d = DRAIN;
        end
      end
      // counter reaching zero means the last product has landed in ACC_Result
      DRAIN: if (cnt_q == '0) begin
        rd_d    = mac_acc;
        rv_d    = 1'b1;
        state_d = HOLD;
      end else begin
        cnt_d = cnt_q - LEN_W'(1);
      end
      HOLD: if (res_ready) begin
        rv_d    = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge Asynch_Reset_n) begin
    if (!Asynch_Reset_n) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      a_q     <= 16'h0000;
      b_q     <= 16'h0000;
      mrst_q  <= 1'b1;
      rv_q    <= 1'b0;
      rd_q    <= 16'h0000;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mrst_q  <= mrst_d;
      rv_q    <= rv_d;
      rd_q    <= rd_d;
    end
  end
endmodule

// File: tb/tb_mac_dot_sequencer.sv
// tb_mac_dot_sequencer: directed bench with a behavioural 3-stage FP16 MAC
// attached to the sequencer; expected results are hand-computed constants.
module tb_mac_dot_sequencer;
  logic        clk = 1'b0;
  logic        Asynch_Reset_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  vec_len = '0;
  logic        in_valid = 1'b0;
  logic [15:0] in_a = '0, in_b = '0;
  logic        in_ready, mac_rst, res_valid, busy;
  logic [15:0] mac_numA, mac_numB, mac_acc, res_data;
  logic        res_ready = 1'b0;
  int          n_checks = 0, n_fail = 0;
  real         p1 = 0.0, p2 = 0.0, acc = 0.0;

  mac_dot_sequencer dut (
    .clk(clk), .Asynch_Reset_n(Asynch_Reset_n), .start(start), .vec_len(vec_len),
    .in_valid(in_valid), .in_a(in_a), .in_b(in_b), .in_ready(in_ready),
    .mac_numA(mac_numA), .mac_numB(mac_numB), .mac_rst(mac_rst), .mac_acc(mac_acc),
    .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic real h2r(input logic [15:0] h);
    real m;
    int  e;
    m = real'(h[9:0]) / 1024.0;
    e = int'(h[14:10]);
    if (e != 0) m = m + 1.0;
    else e = 1;
    for (int i = 0; i < 15; i++) m = m / 2.0;
    for (int i = 0; i < e; i++) m = m * 2.0;
    return h[15] ? -m : m;
  endfunction

  function automatic logic [15:0] r2h(input real v);
    logic s;
    int   e;
    if (v == 0.0) return 16'h0000;
    s = v < 0.0;
    if (s) v = -v;
    e = 15;
    while (v >= 2.0) begin v = v / 2.0; e++; end
    while (v < 1.0)  begin v = v * 2.0; e--; end
    return {s, 5'(e), 10'($rtoi((v - 1.0) * 1024.0))};
  endfunction

  // behavioural MAC: product, pipe, accumulate -> 3 clocks to ACC_Result
  always @(posedge clk or posedge mac_rst) begin
    if (mac_rst) begin
      p1 <= 0.0; p2 <= 0.0; acc <= 0.0;
    end else begin
      p1  <= h2r(mac_numA) * h2r(mac_numB);
      p2  <= p1;
      acc <= acc + p2;
    end
  end
  always_comb mac_acc = r2h(acc);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic do_start(input logic [7:0] len);
    start = 1'b1; vec_len = len;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic feed_pair(input logic [15:0] a, input logic [15:0] b, input int gap);
    int t = 0;
    in_valid = 1'b0; in_a = 16'hFFFF; in_b = 16'hFFFF;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      check("bubble_a", mac_numA, 16'h0000);
      check("bubble_b", mac_numB, 16'h0000);
    end
    while (!in_ready && t < 20) begin @(negedge clk); t++; end
    check("in_ready", in_ready, 1);
    in_valid = 1'b1; in_a = a; in_b = b;
    @(negedge clk);
    check("num_a", mac_numA, a);
    check("num_b", mac_numB, b);
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input logic [15:0] exp);
    for (int k = 0; k < 4; k++) begin
      check("early_valid", res_valid, 0);
      @(negedge clk);
    end
    check("res_valid", res_valid, 1);
    check("res_data", res_data, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_mac_rst", mac_rst, 1);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 16'h0000);
    check("rst_nums", {mac_numA, mac_numB}, 32'h0);
    Asynch_Reset_n = 1'b1;
    @(negedge clk);
    check("rel_mac_rst", mac_rst, 0);
    check("rel_busy", busy, 0);

    // basic 3-pair vector, consecutive cycles
    res_ready = 1'b1;
    do_start(8'd3);
    check("clr_pulse", mac_rst, 1);
    check("clr_busy", busy, 1);
    feed_pair(16'h3C00, 16'h4000, 0);
    feed_pair(16'h4000, 16'h4000, 0);
    feed_pair(16'h4200, 16'h3800, 0);
    wait_result(16'h4780);
    @(negedge clk);
    check("pop_valid", res_valid, 0);
    check("pop_busy", busy, 0);

    // same vector with two-cycle bubbles between pairs
    do_start(8'd3);
    feed_pair(16'h3C00, 16'h4000, 0);
    feed_pair(16'h4000, 16'h4000, 2);
    feed_pair(16'h4200, 16'h3800, 2);
    wait_result(16'h4780);
    @(negedge clk);

    // zero length goes straight to HOLD without touching the MAC
    res_ready = 1'b0;
    do_start(8'd0);
    check("zl_valid", res_valid, 1);
    check("zl_data", res_data, 16'h0000);
    check("zl_no_mac_rst", mac_rst, 0);
    res_ready = 1'b1;
    @(negedge clk);
    check("zl_pop", res_valid, 0);
    res_ready = 1'b0;

    // single pair under backpressure, stray starts in HOLD
    do_start(8'd1);
    check("bp_clr", mac_rst, 1);
    feed_pair(16'h4000, 16'h4200, 0);
    wait_result(16'h4600);
    for (int i = 0; i < 10; i++) begin
      start = 1'b1; vec_len = 8'd3;
      @(negedge clk);
      check("bp_valid", res_valid, 1);
      check("bp_data", res_data, 16'h4600);
      check("bp_no_clr", mac_rst, 0);
    end
    res_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("bp_pop", res_valid, 0);
    check("bp_idle", busy, 0);
    @(negedge clk);
    check("bp_start_ignored", {busy, mac_rst}, 2'b00);

    // back-to-back vectors must not share accumulation
    do_start(8'd1);
    feed_pair(16'h3C00, 16'h3C00, 0);
    wait_result(16'h3C00);
    @(negedge clk);
    do_start(8'd1);
    check("b2b_clr", mac_rst, 1);
    feed_pair(16'h4000, 16'h4000, 0);
    wait_result(16'h4400);
    @(negedge clk);

    // reset in the middle of a 5-pair vector
    do_start(8'd5);
    feed_pair(16'h3C00, 16'h3C00, 0);
    feed_pair(16'h4000, 16'h4000, 0);
    Asynch_Reset_n = 1'b0;
    #1;
    check("mid_mac_rst", mac_rst, 1);
    check("mid_busy", busy, 0);
    check("mid_in_ready", in_ready, 0);
    check("mid_nums", {mac_numA, mac_numB}, 32'h0);
    repeat (2) @(negedge clk);
    Asynch_Reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("mid_no_result", {res_valid, busy}, 2'b00);
    end
    do_start(8'd1);
    feed_pair(16'h3C00, 16'h3800, 0);
    wait_result(16'h3800);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mac_dot_sequencer.md
Name: mac_dot_sequencer

Overview:
- Upstream control stage for the 3-stage FP16 MAC.
- Accepts a vector of FP16 operand pairs over a valid/ready stream and presents one pair per cycle to the MAC's numA/numB inputs, driving +0 operands in idle and bubble cycles.
- Clears the MAC accumulator before each vector, waits out the MAC pipeline latency, then captures ACC_Result and holds it in a result register behind a valid/ready handshake.
- Turns the free-running MAC into a transaction-based dot-product engine.

Parameters:
- LEN_W, 8, width of the vector-length input; maximum vector length is 2^LEN_W-1.
- MAC_LAT, 3, MAC pipeline depth in clocks from operands present on numA/numB to the accumulated value visible on ACC_Result.

Ports:
- clk  input  1  system clock, rising edge.
- Asynch_Reset_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to begin a vector; sampled only in IDLE.
- vec_len  input  LEN_W  number of operand pairs; sampled with start.
- in_valid  input  1  operand pair valid.
- in_a  input  16  FP16 operand A.
- in_b  input  16  FP16 operand B.
- in_ready  output  1  sequencer accepts a pair this cycle.
- mac_numA  output  16  registered operand to MAC numA.
- mac_numB  output  16  registered operand to MAC numB.
- mac_rst  output  1  registered active-high reset to the MAC Asynch_Reset.
- mac_acc  input  16  MAC ACC_Result.
- res_valid  output  1  dot-product result available.
- res_data  output  16  FP16 dot-product result.
- res_ready  input  1  consumer accepts the result.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on Asynch_Reset_n.
- Reset values: state=IDLE, mac_numA=mac_numB=16'h0000, mac_rst=1, res_valid=0, res_data=16'h0000, in_ready=0, busy=0, counters=0.
  - mac_rst stays 1 while reset is held and drops on the first clock edge after release.
- All outputs except in_ready and busy are registered. in_ready and busy are decoded from state.
- States: IDLE, CLEAR, FEED, DRAIN, HOLD.
- IDLE:
  - Operands are +0 and mac_rst=0.
  - start with vec_len!=0: latch vec_len, go to CLEAR.
  - start with vec_len==0: load res_data=16'h0000 and go directly to HOLD; the MAC is untouched.
- CLEAR:
  - mac_rst=1 for exactly one cycle, operands +0.
  - Next state is FEED; the accepted-pair counter is cleared.
- FEED:
  - in_ready=1.
  - On in_valid&in_ready, register in_a/in_b onto mac_numA/mac_numB for one cycle and increment the counter.
  - Any cycle without a handshake drives +0/+0, which adds +0 to the accumulator (bubble-tolerant).
  - The handshake that makes count==latched length moves the FSM to DRAIN, with the drain counter loaded to MAC_LAT.
- DRAIN:
  - in_ready=0, operands +0.
  - Decrement each cycle. When the counter is 0, capture mac_acc into res_data, set res_valid=1 and go to HOLD.
  - Net timing: res_valid rises on the (MAC_LAT+1)-th rising edge after the final input handshake edge (4 for default).
- HOLD:
  - res_valid=1 and res_data stable.
  - On res_ready, clear res_valid and go to IDLE on the same edge.
  - A start in the same cycle is ignored; start must be re-issued from IDLE.
- start outside IDLE is ignored. in_valid outside FEED is ignored; in_ready is 0 there.
- Counters are LEN_W bits and never wrap: the vector length is bounded by vec_len ≤ 2^LEN_W-1.
- Reset asserted mid-operation:
  - Immediate return to reset values and mac_rst=1, so the MAC pipeline and accumulator clear.
  - Any partially fed vector is discarded and no result is produced.
- Back-to-back vectors: every vector passes through CLEAR, so no accumulation carries over between results.

Test Plan:
- Reset release: hold Asynch_Reset_n low 3 cycles, then release -> mac_rst=1 during reset, 0 after the first edge; all other outputs are at reset values; busy=0.
- Basic dot product: vec_len=3, pairs (3C00,4000),(4000,4000),(4200,3800) on consecutive cycles, res_ready=1 -> one mac_rst pulse before the first pair; res_valid on the 4th edge after the last handshake; res_data=16'h4780 (7.5).
- Bubbles: same vector with in_valid low for 2 cycles between each pair -> same res_data 16'h4780; mac_numA/B=0000 during bubble cycles.
- Zero length and backpressure: vec_len=0 -> res_valid the cycle after start with res_data=0000 and no mac_rst pulse. Then vec_len=1 (4000,4200) with res_ready low for 10 cycles -> res_data=4600 (6.0) held stable; start pulses during HOLD are ignored.
- Back-to-back: vector A {(3C00,3C00)} followed immediately by vector B {(4000,4000)} -> results 3C00 then 4400; B is not contaminated by A.
- Mid-operation reset: assert reset after 2 of 5 pairs -> state IDLE, mac_rst=1, res_valid never asserts. A fresh vector_len=1 (3C00,3800) then yields 3800.
